// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between the fetch stage
// (master) and the instruction memory (slave). One request outstanding at a time.
interface fetch_unit_if;

    logic        imem_req;    // request strobe, one cycle per request
    logic [31:0] imem_addr;   // request address, valid while imem_req
    logic        imem_valid;  // response strobe
    logic [31:0] imem_rdata;  // instruction word, valid while imem_valid

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID pipeline register.
// Holds the PC, issues one instruction-memory request at a time, captures the returned
// word into IF/ID and steers the PC from the decoder's PC_src redirect code, flushing
// wrong-path words. A word that arrives while ID is stalled is parked in a hold buffer.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_flush_cnt redirect counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic [1:0]          PC_src,
    input  logic [31:0]         Branch_target,
    input  logic [31:0]         Jr_target,
    input  logic                Stall,
    output logic [31:0]         ID_instruction,
    output logic [31:0]         ID_PC_plus4,
    output logic                ID_valid,
    output logic [31:0]         IF_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;   // outstanding response belongs to a flushed path
    logic [31:0] hold_q, hold_d;         // word that arrived while ID was stalled
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        load_word;
    logic [31:0] load_data;

    assign pc_plus4 = pc_q + 32'd4;

    // Qualify the redirect code: branches override Stall, ID-stage jumps wait for it.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = Jr_target;
        case (PC_src)
            2'b01: begin
                redirect        = 1'b1;
                redirect_target = Branch_target;
            end
            2'b10: begin
                redirect        = !Stall;
                redirect_target = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
            end
            2'b11: begin
                redirect        = !Stall;
                redirect_target = Jr_target;
            end
            default: begin
                redirect        = 1'b0;
                redirect_target = Jr_target;
            end
        endcase
    end

    // Fetch FSM next state, PC steering and IF/ID load; a redirect wins over everything.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        hold_d    = hold_q;
        load_word = 1'b0;
        load_data = '0;

        // With no new word, a stalled ID keeps its instruction; otherwise it gets a bubble.
        if (Stall) begin
            id_instr_d = id_instr_q;
            id_pc4_d   = id_pc4_q;
            id_valid_d = id_valid_q;
        end else begin
            id_instr_d = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
        end

        case (state_q)
            StFetch: begin
                // The request goes out regardless; a redirect marks its response as stale.
                state_d   = StWait;
                discard_d = redirect;
            end
            StWait: begin
                if (imem.imem_valid) begin
                    state_d   = StFetch;
                    discard_d = 1'b0;
                    if (!redirect && !discard_q) begin
                        if (!Stall) begin
                            load_word = 1'b1;
                            load_data = imem.imem_rdata;
                        end else begin
                            hold_d  = imem.imem_rdata;
                            state_d = StHold;
                        end
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect) begin
                    state_d = StFetch;
                end else if (!Stall) begin
                    load_word = 1'b1;
                    load_data = hold_q;
                    state_d   = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (redirect) begin
            pc_d       = redirect_target;
            hold_d     = '0;
            id_instr_d = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
        end else if (load_word) begin
            pc_d       = pc_plus4;
            id_instr_d = load_data;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset; abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            hold_q     <= '0;
            id_instr_q <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            hold_q     <= hold_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_cnt_q;

    // Count every qualified redirect; wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_cnt_q <= '0;
        end else if (redirect) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_flush_cnt = flush_cnt_q;
`endif

    // Request strobe depends only on state, gated off while reset is held.
    assign imem.imem_req  = (state_q == StFetch) && reset;
    assign imem.imem_addr = pc_q;

    assign ID_instruction = id_instr_q;
    assign ID_PC_plus4    = id_pc4_q;
    assign ID_valid       = id_valid_q;
    assign IF_PC          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized stall/redirect/latency traffic,
// checked every cycle against a transaction-level reference model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic [1:0]  PC_src;
    logic [31:0] Branch_target;
    logic [31:0] Jr_target;
    logic        Stall;
    logic [31:0] ID_instruction;
    logic [31:0] ID_PC_plus4;
    logic        ID_valid;
    logic [31:0] IF_PC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_flush_cnt;
`endif

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(ResetPc)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (bus),
        .PC_src         (PC_src),
        .Branch_target  (Branch_target),
        .Jr_target      (Jr_target),
        .Stall          (Stall),
        .ID_instruction (ID_instruction),
        .ID_PC_plus4    (ID_PC_plus4),
        .ID_valid       (ID_valid),
        .IF_PC          (IF_PC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_flush_cnt(fetch_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: one pending request with a countdown to its response.
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    int          lat      = 1;

    // Reference model: PC, whether a request is in flight (and whether it is stale),
    // whether a stalled word is parked, and the IF/ID contents.
    logic [31:0] m_pc        = '0;
    logic        m_busy      = 1'b0;
    logic        m_doomed    = 1'b0;
    logic        m_held      = 1'b0;
    logic [31:0] m_held_word = '0;
    logic [31:0] m_id_instr  = '0;
    logic [31:0] m_id_pc4    = '0;
    logic        m_id_valid  = 1'b0;
    logic [31:0] m_cnt       = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0040_0000) return 32'h2008_0005;
        if (addr == 32'h0040_0004) return 32'h0810_0010;
        return addr ^ {addr[15:0], addr[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = ResetPc;
        m_busy     = 1'b0;
        m_doomed   = 1'b0;
        m_held     = 1'b0;
        m_held_word = '0;
        m_id_instr = '0;
        m_id_pc4   = '0;
        m_id_valid = 1'b0;
        m_cnt      = '0;
    endtask

    // Advance the model by one clock given the inputs of this cycle.
    task automatic model_step(input logic resp, input logic [31:0] word);
        logic        redir;
        logic [31:0] tgt;
        logic        deliver;
        logic [31:0] dword;
        redir = (PC_src == 2'b01) || (PC_src[1] && !Stall);
        if (PC_src == 2'b01)      tgt = Branch_target;
        else if (PC_src == 2'b10) tgt = {m_id_pc4[31:28], m_id_instr[25:0], 2'b00};
        else                      tgt = Jr_target;
        deliver = 1'b0;
        dword   = '0;
        if (!m_busy && !m_held) begin
            m_busy   = 1'b1;
            m_doomed = redir;
        end else if (m_busy) begin
            if (resp) begin
                m_busy = 1'b0;
                if (!redir && !m_doomed) begin
                    if (!Stall) begin
                        deliver = 1'b1;
                        dword   = word;
                    end else begin
                        m_held      = 1'b1;
                        m_held_word = word;
                    end
                end
                m_doomed = 1'b0;
            end else if (redir) begin
                m_doomed = 1'b1;
            end
        end else if (!redir && !Stall) begin
            deliver = 1'b1;
            dword   = m_held_word;
            m_held  = 1'b0;
        end
        if (redir) begin
            m_pc       = tgt;
            m_held     = 1'b0;
            m_id_instr = '0;
            m_id_pc4   = '0;
            m_id_valid = 1'b0;
            m_cnt      = m_cnt + 32'd1;
        end else if (deliver) begin
            m_id_instr = dword;
            m_id_pc4   = m_pc + 32'd4;
            m_id_valid = 1'b1;
            m_pc       = m_pc + 32'd4;
        end else if (!Stall) begin
            m_id_instr = '0;
            m_id_pc4   = '0;
            m_id_valid = 1'b0;
        end
    endtask

    // One clock: drive the memory response, check the request, clock, check registers.
    task automatic step();
        logic        resp;
        logic        exp_req;
        logic        req_seen;
        logic [31:0] addr_seen;
        resp = mem_busy && (mem_cnt == 1);
        bus.imem_valid = resp;
        bus.imem_rdata = resp ? mem_word(mem_addr) : $urandom();
        #1;
        exp_req = reset && !m_busy && !m_held;
        check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
        req_seen  = bus.imem_req;
        addr_seen = bus.imem_addr;
        if (!reset) model_reset();
        else        model_step(resp, bus.imem_rdata);
        @(posedge clk);
        #1;
        if (!reset || resp) mem_busy = 1'b0;
        else if (mem_busy)  mem_cnt--;
        if (req_seen) begin
            mem_busy = 1'b1;
            mem_cnt  = lat;
            mem_addr = addr_seen;
        end
        check("IF_PC", IF_PC, m_pc);
        check("ID_instruction", ID_instruction, m_id_instr);
        check("ID_PC_plus4", ID_PC_plus4, m_id_pc4);
        check("ID_valid", {31'b0, ID_valid}, {31'b0, m_id_valid});
`ifdef FETCH_PERF_CNT_EN
        check("fetch_flush_cnt", fetch_flush_cnt, m_cnt);
`endif
    endtask

    // Step until a request is on the bus, bounded; a timeout counts as a failure.
    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (bus.imem_req) found = 1'b1;
            else              step();
        end
        check({tag, "_found"}, {31'b0, found}, 32'd1);
        check({tag, "_addr"}, bus.imem_addr, exp_addr);
    endtask

    initial begin
        int r;
        reset         = 1'b0;
        PC_src        = 2'b00;
        Branch_target = '0;
        Jr_target     = '0;
        Stall         = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;

        // Reset values
        step();
        step();
        check("rst_pc", IF_PC, ResetPc);
        check("rst_id_valid", {31'b0, ID_valid}, 32'd0);
        check("rst_id_instr", ID_instruction, 32'd0);
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);

        // First fetch with 1-cycle memory
        reset = 1'b1;
        lat   = 1;
        step();
        step();
        check("first_instr", ID_instruction, 32'h2008_0005);
        check("first_pc4", ID_PC_plus4, 32'h0040_0004);
        check("first_valid", {31'b0, ID_valid}, 32'd1);

        // Stall across a response: word parked, IF/ID held, PC advances once
        Stall = 1'b1;
        step();
        step();
        step();
        check("stall_hold_instr", ID_instruction, 32'h2008_0005);
        check("stall_hold_pc", IF_PC, 32'h0040_0004);
        Stall = 1'b0;
        step();
        check("stall_release_instr", ID_instruction, 32'h0810_0010);
        check("stall_release_pc4", ID_PC_plus4, 32'h0040_0008);
        check("stall_release_pc", IF_PC, 32'h0040_0008);

        // j redirect from FETCH
        PC_src = 2'b10;
        step();
        PC_src = 2'b00;
        check("j_bubble", {31'b0, ID_valid}, 32'd0);
        wait_req("j_target", 32'h0040_0040);

        // Branch redirect in WAIT with 3-cycle memory
        lat = 3;
        step();
        PC_src        = 2'b01;
        Branch_target = 32'h0040_0100;
        step();
        PC_src = 2'b00;
        check("br_bubble", {31'b0, ID_valid}, 32'd0);
        wait_req("br_target", 32'h0040_0100);

        // jr held off by Stall, taken once Stall drops
        lat = 1;
        step();
        Stall     = 1'b1;
        PC_src    = 2'b11;
        Jr_target = 32'h0040_1230;
        step();
        step();
        check("jr_stalled_pc", IF_PC, 32'h0040_0100);
        Stall = 1'b0;
        step();
        PC_src = 2'b00;
        check("jr_pc", IF_PC, 32'h0040_1230);
        wait_req("jr_target", 32'h0040_1230);

        // Reset during WAIT
        lat = 3;
        step();
        reset = 1'b0;
        step();
        check("wrst_pc", IF_PC, ResetPc);
        check("wrst_valid", {31'b0, ID_valid}, 32'd0);
        check("wrst_req", {31'b0, bus.imem_req}, 32'd0);
        reset = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            lat   = int'($urandom_range(1, 4));
            Stall = ($urandom_range(0, 9) < 3);
            r     = int'($urandom_range(0, 19));
            if (r < 14)      PC_src = 2'b00;
            else if (r < 16) PC_src = 2'b01;
            else if (r < 18) PC_src = 2'b10;
            else             PC_src = 2'b11;
            Branch_target = $urandom();
            Jr_target     = $urandom();
            reset         = ($urandom_range(0, 199) != 0);
            step();
        end
        reset  = 1'b1;
        PC_src = 2'b00;
        Stall  = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with IF/ID pipeline register.
- Holds the PC and issues one instruction-memory request at a time.
- Captures the returned word into the IF/ID register, where it drives the ID-stage decoder's `ID_instruction` input.
- Consumes the decoder's `PC_src` redirect code to steer the PC, and flushes wrong-path instructions.
- It is the producer end of the decoder's instruction/`PC_src` interface.

## Interface
Parameters:
- `RESET_PC`, default `32'h0040_0000`: PC value loaded by reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous and active-low.
- `PC_src` in 2: redirect code. 00 = PC+4, 01 = branch taken (EX), 10 = j/jal (ID), 11 = jr/jalr (ID).
- `Branch_target` in 32: EX-stage branch target, used when `PC_src`=01.
- `Jr_target` in 32: forwarded rs value, used when `PC_src`=11.
- `Stall` in 1: load-use hazard; ID must hold its current instruction.
- `imem_req` out 1: request strobe, one cycle per request.
- `imem_addr` out 32: request address, equal to PC, valid while `imem_req`=1.
- `imem_valid` in 1: response strobe, arrives at least 1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, valid while `imem_valid`=1.
- `ID_instruction` out 32: IF/ID instruction; 32'h0 (nop) when bubbled.
- `ID_PC_plus4` out 32: IF/ID PC+4 of that instruction.
- `ID_valid` out 1: IF/ID holds a real instruction.
- `IF_PC` out 32: current fetch PC.

## Operation
States and transitions:
- **FETCH**: `imem_req`=1, `imem_addr`=PC; next state WAIT.
- **WAIT**: wait for `imem_valid`.
  - If `discard`=1: drop the word, clear `discard`, go to FETCH.
  - Else if `Stall`=0: load IF/ID with {word, PC+4, valid=1}, set PC<=PC+4, go to FETCH.
  - Else (`Stall`=1): store the word in the hold buffer, go to HOLD.
- **HOLD**: when `Stall`=0, load IF/ID from the hold buffer, set PC<=PC+4, go to FETCH.

IF/ID register when no new word is delivered:
- `Stall`=1: hold the current contents.
- `Stall`=0: load a bubble (0, 0, valid=0).

Redirect qualification:
- `PC_src`=01 is taken unconditionally and overrides `Stall`.
- `PC_src`=10 and 11 are taken only when `Stall`=0.

Redirect target:
- 01: `Branch_target`.
- 10: {`ID_PC_plus4`[31:28], `ID_instruction`[25:0], 2'b00}.
- 11: `Jr_target`.

Redirect action, in the same edge:
- PC <= target.
- IF/ID <= bubble.
- Hold buffer is dropped.
- WAIT with no response this cycle: set `discard`=1, stay in WAIT.
- WAIT with `imem_valid` this cycle: drop the word, go to FETCH.
- FETCH: the request issued this cycle goes out; set `discard`=1, go to WAIT.
- HOLD: go to FETCH.
- A redirect overrides the PC+4 update and the IF/ID load from the same cycle.

Arithmetic and reset:
- PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- The PC is not alignment-checked.
- Reset (`reset`=0 at an edge): PC=`RESET_PC`, state=FETCH, `discard`=0, hold buffer cleared, `ID_instruction`=0, `ID_PC_plus4`=0, `ID_valid`=0.
- `imem_req` is forced to 0 while `reset`=0.
- A request outstanding at reset is abandoned. The memory must also be reset, or its response will be misattributed.

## Timing
- `imem_req` is a function of state only; there is no combinational path from `PC_src` or `Stall`.
- First request is issued in the cycle after reset is released.
- With 1-cycle memory: FETCH at n, `imem_valid` at n+1, `ID_instruction` valid at n+2, next FETCH at n+2. Throughput is 1 instruction per 2 cycles.
- Memory latency L cycles gives throughput of 1 instruction per L+1 cycles.
- At most one request is outstanding. `imem_valid` outside WAIT is ignored.
- Branch redirect at edge n: IF/ID is a bubble in cycle n+1, and the target request is issued no later than the first FETCH after any discard completes.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined: adds output `fetch_flush_cnt` [31:0]. Reset to 0; increments by 1 on every qualified redirect; wraps at 2^32.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset release, 1-cycle memory returning 32'h2008_0005 at 32'h0040_0000 → `imem_req` at cycle 1; `ID_instruction`=32'h2008_0005 and `ID_PC_plus4`=32'h0040_0004 at cycle 3.
- `Stall`=1 for 3 cycles while a response arrives → HOLD entered; IF/ID unchanged; the held word appears in the cycle after `Stall` falls; PC advances only once.
- j with `ID_instruction`=32'h0810_0010 and `ID_PC_plus4`=32'h0040_0008 → next request to 32'h0040_0040; IF/ID becomes a bubble.
- `PC_src`=01 with `Branch_target`=32'h0040_0100, issued in WAIT with memory latency 3 → stale word dropped; next request to 32'h0040_0100; `ID_valid`=0 meanwhile.
- `PC_src`=11 together with `Stall`=1 → no redirect until `Stall`=0; then the request uses `Jr_target`.
- `reset` asserted during WAIT → outputs return to reset values on the next edge; with `FETCH_PERF_CNT_EN` defined, `fetch_flush_cnt`=0.
